result_unloader: RTL and testbench

//  Downstream of the matrix multiplier top. After a multiplication completes, it reads the
//  M*N accumulator results out of C BRAM Port B through read_en_c/read_addr_c/dout_c.

---
 rtl/matmul_pkg.sv | 23 ++
 rtl/result_skid_fifo.sv | 52 +++++
 rtl/result_unloader.sv | 126 ++++++++++++
 tb/tb_result_unloader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matrix-multiplier result path.
package matmul_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} unload_state_t;

  function automatic int acc_width(input int data_width, input int k);
    return 2 * data_width + ((k > 1) ? $clog2(k) : 1);
  endfunction

  // A single-entry C still needs a one-bit address.
  function automatic int addr_width_c(input int m, input int n);
    int w;
    w = $clog2(m * n);
    return (w > 0) ? w : 1;
  endfunction

  function automatic int idx_width(input int extent);
    int w;
    w = $clog2(extent);
    return (w > 0) ? w : 1;
  endfunction

endpackage

// File: rtl/result_skid_fifo.sv
// Two-entry FIFO carrying a result word plus its row/col/last tags.
module result_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       level;
  logic             do_push;
  logic             do_pop;

  assign empty    = (level == 2'd0);
  assign full     = (level == 2'd2);
  assign count    = level;
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      level  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   level <= level + 2'd1;
        2'b01:   level <= level - 2'd1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/result_unloader.sv
// Streams the M*N accumulator results out of C BRAM port B, row-major, with backpressure.
module result_unloader
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int M            = 3,
  parameter int K            = 3,
  parameter int N            = 3,
  parameter int ACC_WIDTH    = acc_width(DATA_WIDTH, K),
  parameter int ADDR_WIDTH_C = addr_width_c(M, N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_unload,
  output logic                    busy,
  output logic                    done,
  output logic                    read_en_c,
  output logic [ADDR_WIDTH_C-1:0] read_addr_c,
  input  logic [ACC_WIDTH-1:0]    dout_c,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [ACC_WIDTH-1:0]    m_data,
  output logic [idx_width(M)-1:0] m_row,
  output logic [idx_width(N)-1:0] m_col,
  output logic                    m_last
);

  localparam int ROW_W = idx_width(M);
  localparam int COL_W = idx_width(N);
  localparam int TAG_W = ROW_W + COL_W + 1;
  localparam int PAY_W = ACC_WIDTH + TAG_W;
  localparam logic [ADDR_WIDTH_C-1:0] LAST_ADDR = ADDR_WIDTH_C'(M * N - 1);
  localparam logic [COL_W-1:0]        LAST_COL  = COL_W'(N - 1);

  unload_state_t           state, state_next;
  logic [ADDR_WIDTH_C-1:0] ptr;
  logic [ADDR_WIDTH_C-1:0] addr_q;
  logic [ROW_W-1:0]        row_cnt;
  logic [COL_W-1:0]        col_cnt;
  logic                    inflight;
  logic [TAG_W-1:0]        tag_q;
  logic                    issue;
  logic [2:0]              occupancy;

  logic             fifo_pop;
  logic [PAY_W-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       fifo_count;

  assign occupancy = 3'(fifo_count) + 3'(inflight);

  always_comb begin
    state_next = state;
    done       = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: if (start_unload) state_next = READ;
      READ: begin
        // Credit covers the read already in the BRAM pipe, so a push never finds the FIFO full.
        issue = !fifo_full && (occupancy < 3'd2);
        if (issue && ptr == LAST_ADDR) state_next = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty && !inflight) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign read_en_c   = issue;
  assign read_addr_c = issue ? ptr : addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      addr_q   <= '0;
      row_cnt  <= '0;
      col_cnt  <= '0;
      inflight <= 1'b0;
      tag_q    <= '0;
    end else begin
      state    <= state_next;
      inflight <= issue;
      if (state == IDLE && start_unload) begin
        ptr     <= '0;
        row_cnt <= '0;
        col_cnt <= '0;
      end else if (issue) begin
        addr_q <= ptr;
        tag_q  <= {row_cnt, col_cnt, ptr == LAST_ADDR};
        if (ptr != LAST_ADDR) ptr <= ptr + 1'b1;
        if (col_cnt == LAST_COL) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

  assign fifo_pop = m_valid && m_ready;
  assign m_valid  = !fifo_empty;
  assign {m_data, m_row, m_col, m_last} = fifo_rdata;

  result_skid_fifo #(
    .WIDTH (PAY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data ({dout_c, tag_q}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_result_unloader.sv
// Randomized self-checking bench for result_unloader against a queue-based beat model.
module tb_result_unloader;

  localparam int ACC = 34;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_unload;
  logic           busy, done, read_en_c;
  logic [3:0]     read_addr_c;
  logic [ACC-1:0] dout_c;
  logic           m_valid, m_ready, m_last;
  logic [ACC-1:0] m_data;
  logic [1:0]     m_row, m_col;

  logic           s_start, s_busy, s_done, s_ren, s_valid, s_ready, s_last;
  logic [0:0]     s_addr, s_row, s_col;
  logic [ACC-1:0] s_dout, s_data;

  logic [ACC-1:0] mem [9];
  logic [ACC-1:0] s_mem0;

  typedef struct {
    logic [ACC-1:0] data;
    int             row;
    int             col;
    bit             last;
  } beat_t;

  beat_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  always @(posedge clk) if (read_en_c) dout_c <= mem[read_addr_c];
  always @(posedge clk) if (s_ren) s_dout <= s_mem0;

  result_unloader #(.DATA_WIDTH(16), .M(3), .K(3), .N(3)) dut (
    .clk(clk), .rst(rst), .start_unload(start_unload), .busy(busy), .done(done),
    .read_en_c(read_en_c), .read_addr_c(read_addr_c), .dout_c(dout_c),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row),
    .m_col(m_col), .m_last(m_last)
  );

  result_unloader #(.DATA_WIDTH(16), .M(1), .K(3), .N(1)) dut_single (
    .clk(clk), .rst(rst), .start_unload(s_start), .busy(s_busy), .done(s_done),
    .read_en_c(s_ren), .read_addr_c(s_addr), .dout_c(s_dout),
    .m_valid(s_valid), .m_ready(s_ready), .m_data(s_data), .m_row(s_row),
    .m_col(s_col), .m_last(s_last)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode: 0 ready high, 1 ready pattern 1,0,0,1, 2 stall 20 cycles, 3 random ready
  task automatic run_unload(input int mode, input bit restart_at4, input bit rst_at5);
    int             beats, issued, done_cnt, done_cyc, last_cyc, cyc;
    bit             prev_stall, rst_hit, fin, restarted;
    logic [ACC-1:0] prev_data;
    logic [1:0]     prev_row, prev_col;
    logic           prev_last;
    beat_t          e;
    exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      e.data = mem[i]; e.row = i / 3; e.col = i % 3; e.last = (i == 8);
      exp_q.push_back(e);
    end
    beats = 0; issued = 0; done_cnt = 0; done_cyc = -1; last_cyc = -1;
    prev_stall = 0; rst_hit = 0; fin = 0; restarted = 0;
    prev_data = '0; prev_row = '0; prev_col = '0; prev_last = 1'b0;
    @(negedge clk);
    start_unload = 1'b1;
    m_ready = 1'b0;
    for (cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(negedge clk);
      start_unload = 1'b0;
      if (rst_hit) begin
        rst = 1'b0;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", m_valid, 0);
        check_eq("rst_read_en", read_en_c, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_data", m_data, 0);
        repeat (6) begin
          @(negedge clk);
          check_eq("rst_no_done", done, 0);
          check_eq("rst_idle_valid", m_valid, 0);
        end
        return;
      end
      if (cyc == 0) check_eq("busy_after_start", busy, 1);
      if (prev_stall) begin
        check_eq("stall_valid", m_valid, 1);
        check_eq("stall_data", m_data, prev_data);
        check_eq("stall_row", m_row, prev_row);
        check_eq("stall_col", m_col, prev_col);
        check_eq("stall_last", m_last, prev_last);
      end
      if (done) begin
        done_cnt++;
        check_eq("done_latency", cyc - last_cyc, 1);
        check_eq("done_beats", beats, 9);
        done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) check_eq("busy_end", busy, 0);
      if (done_cyc >= 0 && cyc == done_cyc + 2) fin = 1;
      if (mode == 2 && cyc == 19) begin
        check_eq("stall_reads", issued, 2);
        check_eq("stall_m_valid", m_valid, 1);
        check_eq("stall_busy", busy, 1);
      end
      if (read_en_c) begin
        check_eq("credit", ((issued - beats) < 2), 1);
        check_eq("read_addr", read_addr_c, issued);
        issued++;
      end
      if (rst_at5 && beats == 5) begin
        rst = 1'b1;
        m_ready = 1'b0;
        rst_hit = 1;
      end else begin
        case (mode)
          0:       m_ready = 1'b1;
          1:       m_ready = pat[cyc % 4];
          2:       m_ready = (cyc >= 19);
          default: m_ready = 1'($urandom_range(0, 1));
        endcase
        if (restart_at4 && beats == 4 && !restarted) begin
          start_unload = 1'b1;
          restarted = 1;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data; prev_row = m_row; prev_col = m_col; prev_last = m_last;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check_eq("beat_data", m_data, e.data);
          check_eq("beat_row", m_row, e.row);
          check_eq("beat_col", m_col, e.col);
          check_eq("beat_last", m_last, e.last);
        end
        beats++;
        if (beats == 9) last_cyc = cyc;
      end
    end
    check_eq("finished", fin, 1);
    check_eq("done_count", done_cnt, 1);
    check_eq("reads_issued", issued, 9);
    check_eq("beats_total", beats, 9);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start_unload = 1'b0; m_ready = 1'b0;
    s_start = 1'b0; s_ready = 1'b0; s_mem0 = '0;
    for (int i = 0; i < 9; i++) mem[i] = ACC'(i + 100);
    repeat (2) @(negedge clk);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_read_en", read_en_c, 0);
    check_eq("reset_read_addr", read_addr_c, 0);
    check_eq("reset_valid", m_valid, 0);
    check_eq("reset_data", m_data, 0);
    check_eq("reset_row", m_row, 0);
    check_eq("reset_col", m_col, 0);
    check_eq("reset_last", m_last, 0);
    rst = 1'b0;

    run_unload(0, 1'b0, 1'b0);
    run_unload(1, 1'b0, 1'b0);
    run_unload(2, 1'b0, 1'b0);
    run_unload(0, 1'b1, 1'b0);
    run_unload(0, 1'b0, 1'b1);
    run_unload(0, 1'b0, 1'b0);
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 9; i++) mem[i] = ACC'({$urandom, $urandom});
      run_unload(3, 1'b0, 1'b0);
    end

    s_mem0 = 34'h3FFFF;
    @(negedge clk);
    s_start = 1'b1;
    s_ready = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n = 0;
    while (!s_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("single_valid", s_valid, 1);
    check_eq("single_data", s_data, 34'h3FFFF);
    check_eq("single_last", s_last, 1);
    check_eq("single_row", s_row, 0);
    check_eq("single_col", s_col, 0);
    @(negedge clk);
    check_eq("single_done", s_done, 1);
    check_eq("single_valid_after", s_valid, 0);
    @(negedge clk);
    check_eq("single_busy_end", s_busy, 0);
    check_eq("single_done_once", s_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
